// File: rtl/encoder_4x2_evt.sv
// Rising-edge event encoder: four request lines are edge-detected, serialised by
// priority through a pending register, and queued as 2-bit indices in a small FIFO.
module encoder_4x2_evt #(
    parameter int DEPTH     = 4,
    parameter bit PRIO_HIGH = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     d1,
    input  logic                     d2,
    input  logic                     d3,
    input  logic                     d4,
    input  logic                     ready,
    input  logic                     clr_ovf,
    output logic                     a,
    output logic                     b,
    output logic                     valid,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [3:0]    d_vec;
    logic [3:0]    d_q, d_d;
    logic [3:0]    pend_q, pend_d;
    logic [3:0]    evt_edge, req, grant;
    logic [1:0]    mem_q [DEPTH];
    logic [1:0]    mem_d [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          ovf_q, ovf_d;
    logic          pop, push, can_push;
    logic [1:0]    push_idx;

    assign d_vec    = {d4, d3, d2, d1};
    assign evt_edge = d_vec & ~d_q;
    assign req      = pend_q | evt_edge;
    assign valid    = (count_q != '0);
    assign pop      = valid && ready;
    // A pop in the same cycle frees a slot, so a full FIFO can still accept.
    assign can_push = (count_q < CW'(DEPTH)) || pop;

    always_comb begin
        grant = '0;
        if (can_push) begin
            if (PRIO_HIGH) begin
                for (int i = 0; i < 4; i++)
                    if (req[i]) begin
                        grant    = '0;
                        grant[i] = 1'b1;
                    end
            end else begin
                for (int i = 3; i >= 0; i--)
                    if (req[i]) begin
                        grant    = '0;
                        grant[i] = 1'b1;
                    end
            end
        end
    end

    always_comb begin
        push_idx = 2'b00;
        for (int i = 0; i < 4; i++)
            if (grant[i]) push_idx = 2'(i);
    end

    assign push = |grant;

    always_comb begin
        d_d      = d_vec;
        pend_d   = req & ~grant;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        if (push) begin
            mem_d[wr_ptr_q] = push_idx;
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end
        if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        // A repeat edge on a still-pending line is dropped; the older event stays.
        if (|(evt_edge & pend_q & ~grant)) ovf_d = 1'b1;
        else if (clr_ovf)                  ovf_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            d_q      <= d_vec;
            pend_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= 2'b00;
        end else begin
            d_q      <= d_d;
            pend_q   <= pend_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            mem_q    <= mem_d;
        end
    end

    assign {a, b}   = valid ? mem_q[rd_ptr_q] : 2'b00;
    assign count    = count_q;
    assign overflow = ovf_q;
endmodule

// File: tb/tb_encoder_4x2_evt.sv
// Directed bench for encoder_4x2_evt (DEPTH=4, PRIO_HIGH=1).
module tb_encoder_4x2_evt;
    logic       clk = 1'b0;
    logic       rst_n, d1, d2, d3, d4, ready, clr_ovf;
    logic       a, b, valid, overflow;
    logic [2:0] count;
    int         pass_cnt = 0;
    int         tot_cnt  = 0;

    encoder_4x2_evt #(.DEPTH(4), .PRIO_HIGH(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .d1(d1), .d2(d2), .d3(d3), .d4(d4),
        .ready(ready), .clr_ovf(clr_ovf), .a(a), .b(b), .valid(valid),
        .count(count), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_d(input logic [3:0] v);
        {d4, d3, d2, d1} = v;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; set_d(4'b0100); ready = 1'b1; clr_ovf = 1'b0;
        tick(); tick();
        tot_cnt++;
        if ({valid, a, b, count, overflow} !== 7'b0_00_000_0)
            $display("FAIL reset_state got v=%b ab=%b%b cnt=%0d ovf=%b want 0/00/0/0", valid, a, b, count, overflow);
        else pass_cnt++;
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            tot_cnt++;
            if ({valid, count, overflow} !== 5'b0_000_0)
                $display("FAIL held_d3 cyc%0d got v=%b cnt=%0d ovf=%b want 0/0/0", i, valid, count, overflow);
            else pass_cnt++;
        end
        set_d(4'b0000);
        tick();
    endtask

    task automatic test_single_pulse();
        ready = 1'b1;
        set_d(4'b0010);
        tick();
        tot_cnt++;
        if ({valid, a, b, count} !== 6'b1_01_001)
            $display("FAIL pulse_d2 got v=%b ab=%b%b cnt=%0d want 1/01/1", valid, a, b, count);
        else pass_cnt++;
        set_d(4'b0000);
        tick();
        tot_cnt++;
        if ({valid, a, b, count} !== 6'b0_00_000)
            $display("FAIL pulse_d2_drain got v=%b ab=%b%b cnt=%0d want 0/00/0", valid, a, b, count);
        else pass_cnt++;
    endtask

    task automatic fill_all();
        ready = 1'b0;
        set_d(4'b1111);
        tick();
        set_d(4'b0000);
        tick(); tick(); tick();
    endtask

    task automatic test_simultaneous();
        logic [1:0] exp_idx [4];
        exp_idx[0] = 2'b11; exp_idx[1] = 2'b10; exp_idx[2] = 2'b01; exp_idx[3] = 2'b00;
        ready = 1'b0;
        set_d(4'b1111);
        for (int i = 1; i <= 4; i++) begin
            tick();
            set_d(4'b0000);
            tot_cnt++;
            if (count !== 3'(i))
                $display("FAIL simul_count step%0d got %0d want %0d", i, count, i);
            else pass_cnt++;
        end
        ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tot_cnt++;
            if ({valid, a, b} !== {1'b1, exp_idx[i]})
                $display("FAIL simul_pop%0d got v=%b ab=%b%b want 1/%b", i, valid, a, b, exp_idx[i]);
            else pass_cnt++;
            tick();
        end
        tot_cnt++;
        if ({valid, a, b} !== 3'b0_00)
            $display("FAIL simul_empty got v=%b ab=%b%b want 0/00", valid, a, b);
        else pass_cnt++;
    endtask

    task automatic test_overflow();
        logic [1:0] exp_idx [5];
        logic [2:0] exp_cnt [5];
        exp_idx[0] = 2'b11; exp_idx[1] = 2'b10; exp_idx[2] = 2'b01; exp_idx[3] = 2'b00; exp_idx[4] = 2'b00;
        exp_cnt[0] = 3'd4;  exp_cnt[1] = 3'd4;  exp_cnt[2] = 3'd3;  exp_cnt[3] = 3'd2;  exp_cnt[4] = 3'd1;
        fill_all();
        set_d(4'b0001); tick();
        set_d(4'b0000); tick();
        tot_cnt++;
        if (overflow !== 1'b0)
            $display("FAIL ovf_first_pend got %b want 0", overflow);
        else pass_cnt++;
        set_d(4'b0001); tick();
        set_d(4'b0000);
        tot_cnt++;
        if ({overflow, count} !== 4'b1_100)
            $display("FAIL ovf_set got ovf=%b cnt=%0d want 1/4", overflow, count);
        else pass_cnt++;
        ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tot_cnt++;
            if ({valid, a, b, count} !== {1'b1, exp_idx[i], exp_cnt[i]})
                $display("FAIL ovf_pop%0d got v=%b ab=%b%b cnt=%0d want 1/%b/%0d", i, valid, a, b, count, exp_idx[i], exp_cnt[i]);
            else pass_cnt++;
            tick();
        end
        tot_cnt++;
        if ({valid, count} !== 4'b0_000)
            $display("FAIL ovf_empty got v=%b cnt=%0d want 0/0", valid, count);
        else pass_cnt++;
        clr_ovf = 1'b1; tick(); clr_ovf = 1'b0;
        tot_cnt++;
        if (overflow !== 1'b0)
            $display("FAIL ovf_clear got %b want 0", overflow);
        else pass_cnt++;
    endtask

    task automatic test_full_push_pop();
        logic [1:0] exp_idx [4];
        exp_idx[0] = 2'b10; exp_idx[1] = 2'b01; exp_idx[2] = 2'b00; exp_idx[3] = 2'b11;
        fill_all();
        ready = 1'b1;
        set_d(4'b1000);
        tick();
        set_d(4'b0000);
        tot_cnt++;
        if ({count, overflow} !== 4'b100_0)
            $display("FAIL full_pushpop got cnt=%0d ovf=%b want 4/0", count, overflow);
        else pass_cnt++;
        for (int i = 0; i < 4; i++) begin
            tot_cnt++;
            if ({valid, a, b} !== {1'b1, exp_idx[i]})
                $display("FAIL full_order%0d got v=%b ab=%b%b want 1/%b", i, valid, a, b, exp_idx[i]);
            else pass_cnt++;
            tick();
        end
        tot_cnt++;
        if (valid !== 1'b0)
            $display("FAIL full_empty got v=%b want 0", valid);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        ready = 1'b0;
        set_d(4'b1111);
        tick();
        set_d(4'b0000);
        tick(); tick();
        tot_cnt++;
        if (count !== 3'd3)
            $display("FAIL mid_pre got cnt=%0d want 3", count);
        else pass_cnt++;
        rst_n = 1'b0;
        tick();
        tot_cnt++;
        if ({valid, a, b, count, overflow} !== 7'b0_00_000_0)
            $display("FAIL mid_reset got v=%b ab=%b%b cnt=%0d ovf=%b want 0/00/0/0", valid, a, b, count, overflow);
        else pass_cnt++;
        rst_n = 1'b1; ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            tot_cnt++;
            if ({valid, count} !== 4'b0_000)
                $display("FAIL mid_stale cyc%0d got v=%b cnt=%0d want 0/0", i, valid, count);
            else pass_cnt++;
        end
    endtask

    initial begin
        test_reset();
        test_single_pulse();
        test_simultaneous();
        test_overflow();
        test_full_push_pop();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end
endmodule

// File: doc/encoder_4x2_evt.md
Name: encoder_4x2_evt

Overview:
- Event encoder: the return path for the 2-to-4 decoder.
- Watches four request lines d1..d4 for rising edges and encodes each event into the 2-bit index {a,b}.
- Priority logic serialises simultaneous events into a small FIFO, which drains over a valid/ready handshake.
- Sits between one-hot request sources and a consumer that is not ready every cycle.

Parameters:
DEPTH, 4, FIFO entries; power of 2, minimum 2
PRIO_HIGH, 1, 1 = d4 has highest priority, 0 = d1 has highest priority

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  synchronous reset, active-low
d1  input  1  request line 0; encodes to {a,b}=00
d2  input  1  request line 1; encodes to 01
d3  input  1  request line 2; encodes to 10
d4  input  1  request line 3; encodes to 11
ready  input  1  consumer accepts the head entry this cycle
clr_ovf  input  1  clears the overflow flag
a  output  1  encoded index MSB of the FIFO head
b  output  1  encoded index LSB of the FIFO head
valid  output  1  FIFO non-empty
count  output  $clog2(DEPTH)+1  FIFO occupancy, 0..DEPTH
overflow  output  1  sticky flag: an event was lost

Behaviour:
- Clocking and reset:
  - Single clock; reset is synchronous and active-low.
  - All state changes on the rising edge of clk.
- Reset (rst_n=0 at a clock edge):
  - FIFO emptied; count=0, valid=0, {a,b}=00, overflow=0.
  - pend cleared.
  - d_q loads the current {d4,d3,d2,d1}, so a line held high through reset produces no event after release.
- Edge detect:
  - edge[i] = d[i] & ~d_q[i]. Inputs are treated as synchronous to clk.
  - d_q <= d every cycle.
- Pending register pend[3:0]:
  - Each cycle, pend_next = (pend | edge) & ~grant.
  - grant is one-hot: the highest-priority bit of (pend | edge), taken only when a push is possible.
- Push rule: push when (pend | edge) != 0 and (count < DEPTH or a pop occurs in the same cycle).
  - The pushed entry is the 2-bit index of the granted bit.
  - Exactly one push per cycle, at most.
- Pop rule: pop when valid && ready.
  - Push and pop in the same cycle leave count unchanged.
  - A push into a full FIFO with a simultaneous pop is legal.
- Output:
  - {a,b} = head entry when valid=1; {a,b}=00 when empty.
  - {a,b} hold stable while valid && !ready.
- Latency:
  - An edge sampled at clock edge N with an empty FIFO and no competing pend is granted and pushed at N.
  - valid=1 and {a,b} are visible after N, i.e. one cycle.
  - Blocked events wait in pend.
- Overflow:
  - Set when edge[i]=1 while pend[i]=1 and bit i is not granted that cycle (the older event is kept, the new one dropped).
  - Set has priority over a simultaneous clr_ovf; clr_ovf alone clears it.
  - An edge on a non-pending bit is never lost.
- Pointers: read and write pointers wrap modulo DEPTH; count is the authority for full/empty.
- Reset mid-operation: reset discards FIFO contents and pend in the same cycle; no partial pop is presented.
- Simultaneous edges, PRIO_HIGH=1:
  - d4,d3,d2,d1 all rising together produce indices 11, 10, 01, 00 on consecutive cycles.
  - PRIO_HIGH=0 reverses the order.

Test Plan:
- Reset with d3 held high, release, hold d3 high 5 cycles, ready=1 -> valid stays 0, count=0, overflow=0.
- Single pulse on d2, ready=1 -> one cycle later valid=1, {a,b}=01, count=1; next cycle valid=0, {a,b}=00.
- d1..d4 rise on the same edge, ready=0, PRIO_HIGH=1 -> count goes 1,2,3,4 over 4 cycles; then ready=1 pops 11, 10, 01, 00 in order, then valid=0.
- FIFO full (4 entries, ready=0), pulse d1, then pulse d1 again before any pop -> overflow=1; after ready=1 the 5th output is 00, exactly once, then valid=0. Next, clr_ovf=1 -> overflow=0.
- Full FIFO with ready=1 and a new d4 edge in the same cycle -> count stays 4, the new 11 is appended at the tail, no overflow.
- Assert rst_n=0 with count=3 and pend nonzero -> next cycle count=0, valid=0, {a,b}=00, overflow=0, and no stale events appear after release.
